// File: rtl/mem_stage_hs.sv
// Memory pipeline stage between execute and writeback: one op at a time,
// valid/ready request channel, variable-latency response, valid/ready output.
module mem_stage_hs #(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_signext,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_rf_we,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [NB-1:0]   mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_rf_we,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_misalign,
  output logic            busy
);

  localparam bit IS32 = (XLEN == 32);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  function automatic logic misaligned_f(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [OFFW-1:0] mask_v;
    logic            bad_v;
    bad_v = 1'b0;
    case (size)
      2'b00:   mask_v = {OFFW{1'b0}};
      2'b01:   mask_v = OFFW'(3'd1);
      2'b10:   mask_v = OFFW'(3'd3);
      2'b11: begin
        mask_v = OFFW'(3'd7);
        bad_v  = IS32;
      end
      default: mask_v = {OFFW{1'b0}};
    endcase
    return bad_v | (|(off & mask_v));
  endfunction

  function automatic logic [NB-1:0] strobe_f(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [NB-1:0] base_v;
    case (size)
      2'b00:   base_v = NB'(8'h01);
      2'b01:   base_v = NB'(8'h03);
      2'b10:   base_v = NB'(8'h0F);
      default: base_v = {NB{1'b1}};
    endcase
    return base_v << off;
  endfunction

  function automatic logic [XLEN-1:0] replicate_f(input logic [1:0] size, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] rep_v;
    case (size)
      2'b00:   rep_v = {NB{wdata[7:0]}};
      2'b01:   rep_v = {(NB/2){wdata[15:0]}};
      2'b10:   rep_v = {(NB/4){wdata[31:0]}};
      default: rep_v = wdata;
    endcase
    return rep_v;
  endfunction

  // Lane select, then shift the field to the top and back down to extend it.
  function automatic logic [XLEN-1:0] load_fmt_f(input logic [XLEN-1:0] rdata, input logic [OFFW-1:0] off,
                                                 input logic [1:0] size, input logic sx);
    logic [XLEN-1:0] sh_v;
    logic [7:0]      sa_v;
    sh_v = rdata >> {off, 3'b000};
    case (size)
      2'b00:   sa_v = 8'(XLEN - 8);
      2'b01:   sa_v = 8'(XLEN - 16);
      2'b10:   sa_v = 8'(XLEN - 32);
      default: sa_v = 8'd0;
    endcase
    sh_v = sh_v << sa_v;
    if (sx) begin
      sh_v = $signed(sh_v) >>> sa_v;
    end else begin
      sh_v = sh_v >> sa_v;
    end
    return sh_v;
  endfunction

  state_t          state_r, state_nxt_s;
  logic            load_r, signext_r, rf_we_r, misalign_r;
  logic [1:0]      size_r;
  logic [XLEN-1:0] addr_r, pc_r, result_r, wdata_r;
  logic [NB-1:0]   we_r;
  logic [4:0]      rd_r;
  logic            accept_s, misalign_s, mem_op_s;

  assign accept_s   = in_valid & (state_r == ST_IDLE) & ~flush;
  assign mem_op_s   = in_load | in_store;
  assign misalign_s = mem_op_s & misaligned_f(in_size, in_addr[OFFW-1:0]);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and handshake outputs; flush wins over every other event.
  always_comb begin
    state_nxt_s   = state_r;
    mem_req_valid = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    busy          = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept_s) begin
          state_nxt_s = (mem_op_s && !misalign_s) ? ST_REQ : ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        mem_req_valid = ~flush;
        if (flush) begin
          state_nxt_s = mem_req_ready ? ST_DRAIN : ST_IDLE;
        end else if (mem_req_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        // A response landing with the flush is already consumed: nothing left to drain.
        if (mem_rsp_valid) begin
          state_nxt_s = flush ? ST_IDLE : ST_HOLD;
        end else if (flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (flush || out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Op capture on accept; load result replaces the trap/ALU address on response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_r     <= 1'b0;
      signext_r  <= 1'b0;
      rf_we_r    <= 1'b0;
      misalign_r <= 1'b0;
      size_r     <= 2'b00;
      addr_r     <= {XLEN{1'b0}};
      pc_r       <= {XLEN{1'b0}};
      result_r   <= {XLEN{1'b0}};
      wdata_r    <= {XLEN{1'b0}};
      we_r       <= {NB{1'b0}};
      rd_r       <= 5'd0;
    end else if (accept_s) begin
      load_r     <= in_load;
      signext_r  <= in_signext;
      rf_we_r    <= in_rf_we & ~misalign_s;
      misalign_r <= misalign_s;
      size_r     <= in_size;
      addr_r     <= in_addr;
      pc_r       <= in_pc;
      result_r   <= in_addr;
      wdata_r    <= replicate_f(in_size, in_wdata);
      we_r       <= in_store ? strobe_f(in_size, in_addr[OFFW-1:0]) : {NB{1'b0}};
      rd_r       <= in_rd;
    end else if ((state_r == ST_WAIT) && mem_rsp_valid && !flush && load_r) begin
      result_r <= load_fmt_f(mem_rsp_rdata, addr_r[OFFW-1:0], size_r, signext_r);
    end
  end

  assign mem_req_we    = we_r;
  assign mem_req_addr  = {addr_r[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign mem_req_wdata = wdata_r;
  assign out_result    = result_r;
  assign out_rf_we     = rf_we_r;
  assign out_rd        = rd_r;
  assign out_pc        = pc_r;
  assign out_misalign  = misalign_r;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a 32-bit instance for most scenarios and a
// 64-bit instance for the doubleword load with slow memory and writeback.
module tb_mem_stage_hs;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        in_valid = 1'b0, in_load = 1'b0, in_store = 1'b0, in_signext = 1'b0, in_rf_we = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic [31:0] in_addr = 32'h0, in_wdata = 32'h0, in_pc = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] mem_rsp_rdata = 32'h0;
  logic        in_ready, mem_req_valid, out_valid, out_rf_we, out_misalign, busy;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata, out_result, out_pc;
  logic [4:0]  out_rd;

  logic        b_in_valid = 1'b0, b_in_load = 1'b0, b_in_rf_we = 1'b0;
  logic [1:0]  b_in_size = 2'b00;
  logic [63:0] b_in_addr = 64'h0, b_in_pc = 64'h0, b_rsp_rdata = 64'h0;
  logic [4:0]  b_in_rd = 5'd0;
  logic        b_req_ready = 1'b0, b_rsp_valid = 1'b0, b_out_ready = 1'b1;
  logic        b_in_ready, b_req_valid, b_out_valid, b_out_rf_we, b_out_misalign, b_busy;
  logic [7:0]  b_req_we;
  logic [63:0] b_req_addr, b_req_wdata, b_out_result, b_out_pc;
  logic [4:0]  b_out_rd;

  always #5 clk = ~clk;

  mem_stage_hs #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_signext(in_signext),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rf_we(in_rf_we), .in_rd(in_rd), .in_pc(in_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rf_we(out_rf_we), .out_rd(out_rd), .out_pc(out_pc),
    .out_misalign(out_misalign), .busy(busy)
  );

  mem_stage_hs #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_load(b_in_load), .in_store(1'b0), .in_size(b_in_size), .in_signext(1'b0),
    .in_addr(b_in_addr), .in_wdata(64'h0), .in_rf_we(b_in_rf_we), .in_rd(b_in_rd), .in_pc(b_in_pc),
    .mem_req_valid(b_req_valid), .mem_req_ready(b_req_ready), .mem_req_we(b_req_we),
    .mem_req_addr(b_req_addr), .mem_req_wdata(b_req_wdata), .mem_rsp_valid(b_rsp_valid),
    .mem_rsp_rdata(b_rsp_rdata), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_rf_we(b_out_rf_we), .out_rd(b_out_rd), .out_pc(b_out_pc),
    .out_misalign(b_out_misalign), .busy(b_busy)
  );

  // All stimulus changes and samples happen 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive32(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wd, input logic we, input logic [4:0] rd);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_signext = sx;
    in_addr = addr; in_wdata = wd; in_rf_we = we; in_rd = rd; in_pc = addr + 32'h1000;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if ({mem_req_valid, mem_req_we, out_valid, out_misalign, busy} !== 8'h00) begin
      n_err++; $display("FAIL rst_ctrl got=%b exp=00000000", {mem_req_valid, mem_req_we, out_valid, out_misalign, busy}); end
    n_cmp++; if (out_result !== 32'h0) begin n_err++; $display("FAIL rst_result got=%h exp=0", out_result); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive32(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 1'b1, 5'd5);
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL alu_noreq0 got=%b exp=0", mem_req_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h1234 || out_rd !== 5'd5 || out_rf_we !== 1'b1) begin
      n_err++; $display("FAIL alu_out got v=%b r=%h rd=%0d we=%b exp v=1 r=1234 rd=5 we=1", out_valid, out_result, out_rd, out_rf_we); end
    n_cmp++; if (out_pc !== 32'h2234) begin n_err++; $display("FAIL alu_pc got=%h exp=2234", out_pc); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL alu_noreq1 got=%b exp=0", mem_req_valid); end
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL alu_done got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
  endtask

  task automatic test_load(input string nm, input logic [1:0] sz, input logic sx, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr, input logic [31:0] exp_res);
    drive32(1'b1, 1'b0, sz, sx, addr, 32'hFFFF_FFFF, 1'b1, 5'd3);
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || mem_req_we !== 4'b0000) begin
      n_err++; $display("FAIL %s_req got v=%b a=%h we=%b exp v=1 a=%h we=0000", nm, mem_req_valid, mem_req_addr, mem_req_we, exp_addr); end
    tick();
    n_cmp++; if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL %s_wait got v=%b busy=%b exp v=0 busy=1", nm, mem_req_valid, busy); end
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== exp_res) begin
      n_err++; $display("FAIL %s_result got v=%b r=%h exp v=1 r=%h", nm, out_valid, out_result, exp_res); end
    tick();
  endtask

  task automatic test_store_stall();
    drive32(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'hDEADBEEF, 1'b0, 5'd0);
    mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_we !== 4'b1100 || mem_req_wdata !== 32'hBEEFBEEF || mem_req_addr !== 32'h200) begin
        n_err++; $display("FAIL sh_req[%0d] got v=%b we=%b wd=%h a=%h exp v=1 we=1100 wd=beefbeef a=200",
                          i, mem_req_valid, mem_req_we, mem_req_wdata, mem_req_addr); end
      if (i == 3) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h202 || out_rf_we !== 1'b0) begin
      n_err++; $display("FAIL sh_out got v=%b r=%h we=%b exp v=1 r=202 we=0", out_valid, out_result, out_rf_we); end
    tick();
  endtask

  task automatic test_misalign();
    drive32(1'b1, 1'b0, 2'b10, 1'b1, 32'h302, 32'h0, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_noreq got=%b exp=0", mem_req_valid); end
    n_cmp++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_rf_we !== 1'b0 || out_result !== 32'h302) begin
      n_err++; $display("FAIL mis_out got v=%b m=%b we=%b r=%h exp v=1 m=1 we=0 r=302", out_valid, out_misalign, out_rf_we, out_result); end
    tick();
  endtask

  task automatic test_ld64();
    b_in_valid = 1'b1; b_in_load = 1'b1; b_in_size = 2'b11; b_in_addr = 64'h08;
    b_in_rf_we = 1'b1; b_in_rd = 5'd9; b_in_pc = 64'h80; b_req_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n_cmp++; if (b_req_valid !== 1'b1 || b_req_addr !== 64'h08 || b_req_we !== 8'h00) begin
      n_err++; $display("FAIL ld64_req got v=%b a=%h we=%b exp v=1 a=8 we=0", b_req_valid, b_req_addr, b_req_we); end
    tick();
    b_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (b_busy !== 1'b1 || b_out_valid !== 1'b0) begin
      n_err++; $display("FAIL ld64_wait got busy=%b v=%b exp busy=1 v=0", b_busy, b_out_valid); end
    b_rsp_valid = 1'b1; b_rsp_rdata = 64'h8123_4567_89AB_CDEF; b_out_ready = 1'b0;
    tick();
    b_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (b_out_valid !== 1'b1 || b_busy !== 1'b1 || b_out_result !== 64'h8123_4567_89AB_CDEF || b_out_rd !== 5'd9) begin
        n_err++; $display("FAIL ld64_hold[%0d] got v=%b busy=%b r=%h rd=%0d exp v=1 busy=1 r=8123456789abcdef rd=9",
                          i, b_out_valid, b_busy, b_out_result, b_out_rd); end
      if (i == 2) b_out_ready = 1'b1;
      tick();
    end
    n_cmp++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      n_err++; $display("FAIL ld64_done got busy=%b v=%b rdy=%b exp 0 0 1", b_busy, b_out_valid, b_in_ready); end
  endtask

  task automatic test_flush_req();
    drive32(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, 5'd1);
    flush = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_prio got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy); end
    flush = 1'b0; mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL flush_withdraw got=%b exp=0", mem_req_valid); end
    tick();
    flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_req_idle got rdy=%b v=%b exp rdy=1 v=0", in_ready, mem_req_valid); end
  endtask

  task automatic test_flush_wait_and_reset();
    drive32(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 5'd4);
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain got rdy=%b busy=%b v=%b exp 0 1 0", in_ready, busy, out_valid); end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL drain_done got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    drive32(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 1'b1, 5'd6);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500) begin
      n_err++; $display("FAIL next_lw got v=%b a=%h exp v=1 a=500", mem_req_valid, mem_req_addr); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({mem_req_valid, out_valid, busy, in_ready} !== 4'b0001 || mem_req_addr !== 32'h0 || out_rd !== 5'd0) begin
      n_err++; $display("FAIL midreq_reset got v=%b ov=%b busy=%b rdy=%b a=%h rd=%0d exp 0 0 0 1 a=0 rd=0",
                        mem_req_valid, out_valid, busy, in_ready, mem_req_addr, out_rd); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load("lb", 2'b00, 1'b1, 32'h103, 32'h80AA55CC, 32'h100, 32'hFFFFFF80);
    test_load("lbu", 2'b00, 1'b0, 32'h103, 32'h80AA55CC, 32'h100, 32'h00000080);
    test_load("lhu", 2'b01, 1'b0, 32'h106, 32'h9ABC1234, 32'h104, 32'h00009ABC);
    test_store_stall();
    test_misalign();
    test_ld64();
    test_flush_req();
    test_flush_wait_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
